// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared encodings for the data-memory access unit
//
// Purpose: size codes, FSM state type and default memory size used by
// mem_access_unit and mem_lane_align.
// Ports: none (package).
package mem_pkg;

  // Access size encodings as presented on req_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Default byte size of the attached data memory.
  localparam int unsigned ADDR_LIMIT_DEFAULT = 256;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RESP = 2'b11
  } state_t;

  // True when an access of this size at this byte address is misaligned
  // or uses the reserved size code.
  function automatic logic bad_shape(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte/half lane extraction and store merging
//
// Purpose: purely combinational lane steering between a 32-bit memory word
// and a byte address offset, little-endian.
// Ports:
//   word       in  32  word read from memory
//   lane       in  2   byte offset addr[1:0]
//   size       in  2   access size code
//   sign       in  1   sign-extend loaded byte/half
//   wdata      in  32  right-aligned store data
//   load_data  out 32  extracted and extended load result
//   merge_data out 32  word with addressed lanes replaced by wdata
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    // Halfwords are 2-byte aligned, so only lane[1] picks the half.
    half_sel = lane[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{sign & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{sign & half_sel[15]}}, half_sel};
      default: load_data = word;
    endcase

    merge_data = word;
    case (size)
      SZ_BYTE: merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      SZ_HALF: begin
        if (lane[1]) merge_data[31:16] = wdata[15:0];
        else         merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for the word-addressed data memory
//
// Purpose: accepts one core request at a time, checks alignment/size/range,
// performs byte/half/word loads and stores (read-modify-write for sub-word
// stores) and returns a one-cycle response pulse.
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   req_valid/ready  request handshake, ready only in IDLE
//   req_write        1 = store, 0 = load
//   req_size         00 byte, 01 half, 10 word, 11 illegal
//   req_signed       sign-extend loads
//   req_addr         byte address
//   req_wdata        right-aligned store data
//   resp_valid       one-cycle completion pulse
//   resp_rdata       extended load data, 0 for stores/errors
//   resp_error       misaligned, illegal size or out of range
//   MemRead/MemWrite memory strobes, one cycle per access
//   MemAddress       word-aligned address of the captured request
//   WriteData        full word to write
//   ReadData         combinational memory read data
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  state_t      state;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merge_data;

  always_comb begin
    req_err = bad_shape(req_size, req_addr[1:0]) || (req_addr >= ADDR_LIMIT);
  end

  // Driven only from the captured address, so the memory port never sees
  // req_addr combinationally; upper bits pass through untouched.
  assign MemAddress = {addr_q[31:2], 2'b00};

  mem_lane_align u_lane_align (
    .word       (ReadData),
    .lane       (addr_q[1:0]),
    .size       (size_q),
    .sign       (signed_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_error <= 1'b0;
      resp_rdata <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      WriteData  <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is high throughout IDLE, so req_valid alone is the handshake.
          if (req_valid) begin
            write_q   <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_write || (req_size != SZ_WORD)) begin
              // Loads and sub-word stores both start by reading the word.
              state   <= RD;
              MemRead <= 1'b1;
            end else begin
              state     <= WR;
              MemWrite  <= 1'b1;
              WriteData <= req_wdata;
            end
          end
        end

        RD: begin
          MemRead <= 1'b0;
          if (write_q) begin
            state     <= WR;
            MemWrite  <= 1'b1;
            WriteData <= merge_data;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= load_data;
          end
        end

        WR: begin
          MemWrite   <= 1'b0;
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end

        RESP: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
        end

        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          MemRead   <= 1'b0;
          MemWrite  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - self-checking bench for mem_access_unit
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_error;
  logic [31:0] resp_rdata;
  logic        MemRead, MemWrite;
  logic [31:0] MemAddress, WriteData, ReadData;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_LIMIT(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_error(resp_error), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemAddress(MemAddress), .WriteData(WriteData), .ReadData(ReadData)
  );

  // Data memory: combinational read, write on posedge.
  logic [31:0] dmem [64];
  logic        mem_clear;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) dmem[i] <= '0;
    end else if (MemWrite) begin
      dmem[MemAddress[7:2]] <= WriteData;
    end
  end
  assign ReadData = dmem[MemAddress[7:2]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
    int          nrd;
    int          nwr;
    logic [31:0] maddr;
    logic [31:0] wword;
  } exp_t;

  exp_t        expq[$];
  exp_t        ce;
  logic [7:0]  ref_mem [256];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata;
  logic        last_err;
  int          rd_seen = 0;
  int          wr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: actual %h required %h", name, act, expv);
    end
  endtask

  // Transaction-level model: byte-array memory, outcome decided at accept.
  task automatic model_push(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd, input int acc);
    exp_t        e;
    int          n;
    logic [31:0] v, base;
    n       = 1 << sz;
    e.err   = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 256);
    e.rdata = '0;
    e.nrd   = 0;
    e.nwr   = 0;
    e.maddr = {a[31:2], 2'b00};
    e.wword = '0;
    if (e.err) begin
      e.due = acc;
    end else if (!w) begin
      v = '0;
      for (int i = 0; i < n; i++) v |= {24'b0, ref_mem[8'(a + i)]} << (8 * i);
      if (sg && n < 4) v = $signed(v << (32 - 8 * n)) >>> (32 - 8 * n);
      e.rdata = v;
      e.nrd   = 1;
      e.due   = acc + 1;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = wd[8 * i +: 8];
      base = a & ~32'd3;
      for (int i = 0; i < 4; i++) e.wword |= {24'b0, ref_mem[8'(base + i)]} << (8 * i);
      e.nwr = 1;
      e.nrd = (n < 4) ? 1 : 0;
      e.due = acc + ((n < 4) ? 2 : 1);
    end
    expq.push_back(e);
  endtask

  // Per-cycle comparison against the model queue.
  always @(negedge clk) begin
    if (rst) begin
      rd_seen = 0;
      wr_seen = 0;
    end else begin
      chk("strobe_excl", {31'b0, MemRead & MemWrite}, 32'd0);
      if (MemRead || MemWrite) begin
        if (expq.size() == 0) chk("spurious_strobe", 32'd1, 32'd0);
        else begin
          chk("mem_addr", MemAddress, expq[0].maddr);
          if (MemWrite) chk("write_data", WriteData, expq[0].wword);
        end
      end
      if (MemRead)  rd_seen++;
      if (MemWrite) wr_seen++;
      if (resp_valid) begin
        last_rdata = resp_rdata;
        last_err   = resp_error;
        if (expq.size() == 0) chk("spurious_resp", 32'd1, 32'd0);
        else begin
          ce = expq.pop_front();
          chk("resp_rdata", resp_rdata, ce.rdata);
          chk("resp_error", {31'b0, resp_error}, {31'b0, ce.err});
          chk("resp_cycle", 32'(cyc), 32'(ce.due));
          chk("read_pulses", 32'(rd_seen), 32'(ce.nrd));
          chk("write_pulses", 32'(wr_seen), 32'(ce.nwr));
        end
        rd_seen = 0;
        wr_seen = 0;
      end else if (expq.size() > 0 && cyc > expq[0].due) begin
        chk("resp_late", 32'(cyc), 32'(expq[0].due));
        void'(expq.pop_front());
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
      if (n > 50) begin
        $display("FAIL ready_timeout: actual 0 required 1");
        $fatal(1, "req_ready never returned");
      end
    end
  endtask

  // Presents a request and returns just after the accepting edge with
  // req_valid still high, as a core with a queued request would.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    wait_ready();
    model_push(w, sz, sg, a, wd, cyc + 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    req_valid = 1'b0;
    n = 0;
    while (expq.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (expq.size() > 0) chk("drain_timeout", 32'(expq.size()), 32'd0);
    #1;
  endtask

  task automatic one(input logic w, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] wd);
    issue(w, sz, sg, a, wd);
    drain();
  endtask

  initial begin
    logic [1:0]  sz;
    logic [31:0] a;
    int          r;
    rst = 1'b1; mem_clear = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_error", {31'b0, resp_error}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_memread", {31'b0, MemRead}, 32'd0);
    chk("rst_memwrite", {31'b0, MemWrite}, 32'd0);
    chk("rst_memaddr", MemAddress, 32'd0);
    chk("rst_wdata", WriteData, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_clear = 1'b0;

    one(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);
    one(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
    chk("word_load", last_rdata, 32'hDEADBEEF);
    chk("word_load_err", {31'b0, last_err}, 32'd0);

    one(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h80FF7F01);
    one(1'b0, SZ_BYTE, 1'b1, 32'h23, 32'h0);
    chk("lb_signed", last_rdata, 32'hFFFFFF80);
    one(1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0);
    chk("lb_unsigned", last_rdata, 32'h00000080);
    one(1'b0, SZ_HALF, 1'b1, 32'h22, 32'h0);
    chk("lh_signed", last_rdata, 32'hFFFF80FF);

    one(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h11223344);
    one(1'b1, SZ_BYTE, 1'b0, 32'h31, 32'h123456AA);
    chk("sb_mem", dmem[12], 32'h1122AA44);
    one(1'b0, SZ_WORD, 1'b0, 32'h30, 32'h0);
    chk("sb_load", last_rdata, 32'h1122AA44);

    one(1'b0, SZ_HALF, 1'b0, 32'h05, 32'h0);
    chk("err_half_mis", {31'b0, last_err}, 32'd1);
    one(1'b1, SZ_WORD, 1'b0, 32'h06, 32'hFFFFFFFF);
    chk("err_word_mis", {31'b0, last_err}, 32'd1);
    one(1'b0, SZ_ILL, 1'b0, 32'h00, 32'h0);
    chk("err_size", {31'b0, last_err}, 32'd1);
    one(1'b0, SZ_WORD, 1'b0, 32'h100, 32'h0);
    chk("err_range", {31'b0, last_err}, 32'd1);
    chk("err_range_rdata", last_rdata, 32'd0);

    // Reset cuts the WR cycle of a word store to 0x40.
    req_valid = 1'b1; req_write = 1'b1; req_size = SZ_WORD; req_signed = 1'b0;
    req_addr = 32'h40; req_wdata = 32'hCAFEF00D;
    wait_ready();
    @(posedge clk); #1;
    rst = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_memwrite", {31'b0, MemWrite}, 32'd0);
    chk("rstmid_resp", {31'b0, resp_valid}, 32'd0);
    chk("rstmid_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rstmid_no_resp", {31'b0, resp_valid}, 32'd0);
    end
    chk("rstmid_mem", dmem[16], 32'd0);
    chk("rstmid_ready_after", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Continuous req_valid, alternating then random load/store mix.
    for (int i = 0; i < 500; i++) begin
      r = $urandom_range(0, 15);
      sz = (r < 5) ? SZ_BYTE : (r < 10) ? SZ_HALF : (r < 15) ? SZ_WORD : SZ_ILL;
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0 && sz != SZ_ILL) a = a & ~((32'd1 << sz) - 32'd1);
      issue((i < 300) ? i[0] : 1'($urandom), sz, 1'($urandom), a, $urandom);
      if (i >= 300 && $urandom_range(0, 7) == 0) drain();
    end
    drain();

    for (int i = 0; i < 64; i++)
      chk("final_mem", dmem[i], {ref_mem[4*i+3], ref_mem[4*i+2], ref_mem[4*i+1], ref_mem[4*i]});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual timeout required finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the data-memory interface. It sits between the core's execute stage and the word-addressed data memory.
- Accepts one load/store request at a time from the core via valid/ready and drives MemRead/MemWrite/MemAddress/WriteData to memory.
- Memory reads are combinational and memory writes commit on the posedge.
- Adds byte and halfword access: extract plus sign/zero-extend on loads, read-modify-write on sub-word stores.
- Adds alignment and range checking, and returns a one-cycle response pulse.

Parameters:
ADDR_LIMIT, 256, byte size of the data memory. Requests with addr >= ADDR_LIMIT are rejected with an error.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  core presents a request
req_ready  out  1  unit can accept a request; high only in IDLE
req_write  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  32  load result, extended to 32 bits; 0 for stores and errors
resp_error  out  1  qualifies resp_valid: misaligned, illegal size, or out of range
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe, committed at the next posedge
MemAddress  out  32  word-aligned address {addr_q[31:2],2'b00}
WriteData  out  32  full word to write
ReadData  in  32  combinational read data, valid in the same cycle as MemRead

Behaviour:
- State machine: IDLE, RD, WR, RESP. State is a registered encoding; all outputs are decoded from state and captured registers only, with no combinational path from req_* to mem outputs.
- Reset values:
  - state = IDLE, so req_ready = 1.
  - resp_valid = 0, resp_error = 0, resp_rdata = 0.
  - MemRead = 0, MemWrite = 0, MemAddress = 0, WriteData = 0.
  - All captured registers = 0.
- Accept: when req_valid && req_ready at a posedge, capture write, size, signed, addr and wdata. req_valid while not in IDLE is ignored; the core must hold it.
- Error check at accept, with no memory access performed. Any of these goes IDLE -> RESP with resp_error = 1:
  - size == 11
  - half with addr[0] = 1
  - word with addr[1:0] != 0
  - addr >= ADDR_LIMIT
- Load: IDLE -> RD -> RESP -> IDLE.
  - In RD, MemRead = 1. At the end of RD, ReadData is latched and processed:
  - Byte lane k = addr[1:0] is taken from bits [8k+7:8k], little-endian.
  - The halfword is bits [16*addr[1]+15 : 16*addr[1]].
  - The result is extended according to the captured signed flag.
  - Latency: accepted at edge N, resp_valid high in cycle N+2.
- Word store: IDLE -> WR -> RESP.
  - In WR, MemWrite = 1 and WriteData = wdata.
- Sub-word store: IDLE -> RD -> WR -> RESP.
  - RD latches the old word.
  - WR writes the old word with the addressed byte or half lanes replaced by wdata[7:0] or wdata[15:0].
  - Other lanes are preserved bit-exactly.
- Strobe rules:
  - MemRead and MemWrite are never both 1.
  - Each is high for exactly one cycle per access.
  - MemAddress is stable during RD and WR of the same request.
- RESP lasts exactly one cycle: resp_valid = 1, req_ready = 0. Then IDLE.
- No response backpressure: the core must sample resp_valid when it fires.
- Back-to-back requests: the next accept is possible in the cycle after RESP. Minimum issue interval is 3 cycles for a load, 4 for a sub-word store.
- Reset mid-operation: immediate return to IDLE, all strobes drop asynchronously, and no response is issued.
  - A write whose WR cycle is cut by rst before the posedge is not committed.
  - A write completed at an earlier edge stays committed.
- Address bits above the memory index are passed through unchanged in MemAddress. The range check guarantees index validity.

Decomposition:
- Shared package mem_pkg:
  - size encodings SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - state enum IDLE/RD/WR/RESP.
  - default ADDR_LIMIT.
- One natural combinational sub-module, mem_lane_align, with two functions:
  - load extract: word, addr[1:0], size, signed -> 32-bit result.
  - store merge: old word, wdata, addr[1:0], size -> new word.
- The top level holds the FSM, capture registers and error check.

Test Plan:
- Word store addr 0x10, data 0xDEADBEEF, then word load 0x10 -> one MemWrite pulse at 0x10; load resp_rdata = 0xDEADBEEF, resp_error = 0, resp_valid 2 cycles after accept.
- Memory word 0x20 = 0x80FF7F01. Signed byte load at 0x23 -> 0xFFFFFF80. Unsigned byte load at 0x23 -> 0x00000080. Signed half load at 0x22 -> 0xFFFF80FF.
- Word 0x30 = 0x11223344; byte store 0xAA at 0x31 -> RD then WR at 0x30 with WriteData = 0x1122AA44; a later load reads 0x1122AA44.
- Half load at 0x05, word store at 0x06, size 11 at 0x00, and word load at 0x100 -> each gives resp_error = 1, resp_rdata = 0, with no MemRead/MemWrite pulse.
- Assert rst during the WR cycle of a word store to 0x40 holding 0x0 -> state returns to IDLE, no resp_valid, word 0x40 stays 0x0, and req_ready = 1 after release.
- Core holds req_valid continuously with alternating load/store -> each request is accepted only in IDLE, responses arrive in order, and MemRead and MemWrite are never high together.
